// File: rtl/axi_line_refill_pkg.sv
// Shared types and AXI constants for the cache line refill engine.
// Optional error tracking is enabled by defining AXI_LINE_REFILL_ERR_EN.
package axi_line_refill_pkg;

  localparam int unsigned MetaAddrWidth = 64;
  localparam int unsigned MetaTidWidth  = 8;
  localparam int unsigned MetaCntWidth  = 8;

  localparam logic [1:0] AxiBurstIncr = 2'b01;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_AR_WAIT,
    SLOT_DATA,
    SLOT_RTRN
  } slot_state_e;

  // Per-slot bookkeeping, sized for the widest supported configuration
  typedef struct packed {
    logic [MetaAddrWidth-1:0] paddr;
    logic                     nc;
    logic [MetaTidWidth-1:0]  tid;
    logic [MetaCntWidth-1:0]  beat_cnt;
    logic                     err;
  } slot_meta_t;

endpackage

// File: rtl/axi_line_refill_slot.sv
// One refill slot: beat counter, line assembly buffer and sticky error flag.
// The error flag is only kept when AXI_LINE_REFILL_ERR_EN is defined.
module axi_line_refill_slot
  import axi_line_refill_pkg::*;
#(
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned AxiDataWidth = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_alloc,
  input  logic                     i_free,
  input  logic [MetaAddrWidth-1:0] i_paddr,
  input  logic                     i_nc,
  input  logic [MetaTidWidth-1:0]  i_tid,
  input  logic                     i_we,
  input  logic [AxiDataWidth-1:0]  i_data,
  input  logic                     i_last,
  input  logic                     i_resp_err,
  output slot_meta_t               o_meta,
  output logic [LineWidth-1:0]     o_line_c,
  output logic                     o_err_c
);

  localparam int unsigned Beats = LineWidth / AxiDataWidth;

  slot_meta_t              r_meta;
  logic [LineWidth-1:0]    r_line;
  logic [MetaCntWidth-1:0] w_idx;

  assign o_meta = r_meta;

  // Line as it looks with the current beat merged in; nc fills always land in word 0
  always_comb begin
    w_idx    = r_meta.nc ? '0 : r_meta.beat_cnt;
    o_line_c = r_line;
    for (int unsigned w = 0; w < Beats; w++) begin
      if (i_we && (w_idx == MetaCntWidth'(w))) begin
        o_line_c[w*AxiDataWidth +: AxiDataWidth] = i_data;
      end
    end
  end

`ifdef AXI_LINE_REFILL_ERR_EN
  assign o_err_c = r_meta.err | (i_we & i_resp_err);
`else
  logic w_unused_err;
  assign w_unused_err = i_resp_err;
  assign o_err_c      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= '0;
      r_line <= '0;
    end else if (i_alloc) begin
      r_meta.paddr    <= i_paddr;
      r_meta.nc       <= i_nc;
      r_meta.tid      <= i_tid;
      r_meta.beat_cnt <= '0;
      r_meta.err      <= 1'b0;
      r_line          <= '0;
    end else if (i_we) begin
      r_line          <= o_line_c;
      r_meta.beat_cnt <= i_last ? '0 : r_meta.beat_cnt + MetaCntWidth'(1);
`ifdef AXI_LINE_REFILL_ERR_EN
      r_meta.err      <= o_err_c;
`endif
    end else if (i_free) begin
      r_meta.err <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_line_refill.sv
// AXI4 read engine refilling cache lines with up to NumOutstanding concurrent bursts.
// Define AXI_LINE_REFILL_ERR_EN to report r_resp errors on rtrn_err_o.
module axi_line_refill
  import axi_line_refill_pkg::*;
#(
  parameter int unsigned LineWidth      = 128,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned PlenWidth      = 56,
  parameter int unsigned NumOutstanding = 2,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned AxiIdWidth     = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PlenWidth-1:0]    req_paddr_i,
  input  logic                    req_nc_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic [AxiIdWidth-1:0]   r_id_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i,
  output logic                    rtrn_valid_o,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic [TidWidth-1:0]     rtrn_tid_o,
  output logic                    rtrn_err_o,
  output logic                    busy_o
);

  localparam int unsigned Beats     = LineWidth / AxiDataWidth;
  localparam int unsigned LineBytes = LineWidth / 8;
  localparam int unsigned WordBytes = AxiDataWidth / 8;
  localparam int unsigned SlotIdxW  = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam logic [2:0]  ArSize    = 3'($clog2(WordBytes));

  slot_state_e             r_state [NumOutstanding];
  logic                    r_ar_valid;
  logic [AxiAddrWidth-1:0] r_ar_addr;
  logic [7:0]              r_ar_len;
  logic [2:0]              r_ar_size;
  logic [1:0]              r_ar_burst;
  logic [AxiIdWidth-1:0]   r_ar_id;
  logic                    r_rtrn_valid;
  logic [LineWidth-1:0]    r_rtrn_data;
  logic [TidWidth-1:0]     r_rtrn_tid;

  logic                      w_any_free;
  logic                      w_any_busy;
  logic [SlotIdxW-1:0]       w_alloc_idx;
  logic                      w_accept;
  logic [AxiAddrWidth-1:0]   w_paddr_ext;
  logic [AxiAddrWidth-1:0]   w_ar_addr_nxt;
  logic [NumOutstanding-1:0] w_beat_we;
  slot_meta_t                w_meta   [NumOutstanding];
  logic [LineWidth-1:0]      w_line_c [NumOutstanding];
  logic [NumOutstanding-1:0] w_err_c;
  logic [NumOutstanding-1:0] w_unused_meta;
  logic                      w_rtrn_hit;
  logic [LineWidth-1:0]      w_rtrn_line;
  logic [TidWidth-1:0]       w_rtrn_tid;
  logic                      w_rtrn_err;

  // Lowest-index free slot; a slot still in RTRN is not free yet
  always_comb begin
    w_any_free  = 1'b0;
    w_any_busy  = 1'b0;
    w_alloc_idx = '0;
    for (int i = NumOutstanding - 1; i >= 0; i--) begin
      if (r_state[i] == SLOT_IDLE) begin
        w_any_free  = 1'b1;
        w_alloc_idx = SlotIdxW'(i);
      end else begin
        w_any_busy = 1'b1;
      end
    end
  end

  assign req_ready_o = rst_ni & w_any_free & ~r_ar_valid;
  assign w_accept    = req_valid_i & req_ready_o;
  assign busy_o      = w_any_busy | r_ar_valid;
  assign r_ready_o   = 1'b1;

  assign w_paddr_ext   = AxiAddrWidth'(req_paddr_i);
  assign w_ar_addr_nxt = req_nc_i ? (w_paddr_ext & ~AxiAddrWidth'(WordBytes - 1))
                                  : (w_paddr_ext & ~AxiAddrWidth'(LineBytes - 1));

  for (genvar g = 0; g < NumOutstanding; g++) begin : g_slot
    assign w_beat_we[g]     = r_valid_i && (r_id_i == AxiIdWidth'(g)) && (r_state[g] == SLOT_DATA);
    assign w_unused_meta[g] = ^w_meta[g];

    axi_line_refill_slot #(
      .LineWidth    (LineWidth),
      .AxiDataWidth (AxiDataWidth)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_alloc    (w_accept && (w_alloc_idx == SlotIdxW'(g))),
      .i_free     (r_state[g] == SLOT_RTRN),
      .i_paddr    (MetaAddrWidth'(req_paddr_i)),
      .i_nc       (req_nc_i),
      .i_tid      (MetaTidWidth'(req_tid_i)),
      .i_we       (w_beat_we[g]),
      .i_data     (r_data_i),
      .i_last     (r_last_i),
`ifdef AXI_LINE_REFILL_ERR_EN
      .i_resp_err (r_resp_i[1]),
`else
      .i_resp_err (1'b0),
`endif
      .o_meta     (w_meta[g]),
      .o_line_c   (w_line_c[g]),
      .o_err_c    (w_err_c[g])
    );
  end

  // At most one R beat per cycle, so at most one slot completes
  always_comb begin
    w_rtrn_hit  = 1'b0;
    w_rtrn_line = '0;
    w_rtrn_tid  = '0;
    w_rtrn_err  = 1'b0;
    for (int i = 0; i < NumOutstanding; i++) begin
      if (w_beat_we[i] && r_last_i) begin
        w_rtrn_hit  = 1'b1;
        w_rtrn_line = w_line_c[i];
        w_rtrn_tid  = TidWidth'(w_meta[i].tid);
        w_rtrn_err  = w_err_c[i];
      end
    end
  end

  // Slot FSMs, AR channel and return register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumOutstanding; i++) r_state[i] <= SLOT_IDLE;
      r_ar_valid   <= 1'b0;
      r_ar_addr    <= '0;
      r_ar_len     <= '0;
      r_ar_size    <= '0;
      r_ar_burst   <= '0;
      r_ar_id      <= '0;
      r_rtrn_valid <= 1'b0;
      r_rtrn_data  <= '0;
      r_rtrn_tid   <= '0;
    end else begin
      for (int i = 0; i < NumOutstanding; i++) begin
        case (r_state[i])
          SLOT_IDLE:
            if (w_accept && (w_alloc_idx == SlotIdxW'(i))) r_state[i] <= SLOT_AR_WAIT;
          SLOT_AR_WAIT:
            if (r_ar_valid && ar_ready_i && (r_ar_id == AxiIdWidth'(i))) r_state[i] <= SLOT_DATA;
          SLOT_DATA:
            if (w_beat_we[i] && r_last_i) r_state[i] <= SLOT_RTRN;
          default:
            r_state[i] <= SLOT_IDLE;
        endcase
      end

      if (w_accept) begin
        r_ar_valid <= 1'b1;
        r_ar_addr  <= w_ar_addr_nxt;
        r_ar_len   <= req_nc_i ? 8'd0 : 8'(Beats - 1);
        r_ar_size  <= ArSize;
        r_ar_burst <= AxiBurstIncr;
        r_ar_id    <= AxiIdWidth'(w_alloc_idx);
      end else if (ar_ready_i) begin
        r_ar_valid <= 1'b0;
      end

      r_rtrn_valid <= w_rtrn_hit;
      if (w_rtrn_hit) begin
        r_rtrn_data <= w_rtrn_line;
        r_rtrn_tid  <= w_rtrn_tid;
      end
    end
  end

`ifdef AXI_LINE_REFILL_ERR_EN
  logic r_rtrn_err;
  logic w_unused_resp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rtrn_err <= 1'b0;
    end else if (w_rtrn_hit) begin
      r_rtrn_err <= w_rtrn_err;
    end
  end

  assign rtrn_err_o    = r_rtrn_err;
  assign w_unused_resp = r_resp_i[0] ^ (^w_unused_meta);
`else
  logic w_unused_resp;
  assign rtrn_err_o    = 1'b0;
  assign w_unused_resp = (^r_resp_i) ^ w_rtrn_err ^ (^w_unused_meta);
`endif

  assign ar_valid_o   = r_ar_valid;
  assign ar_addr_o    = r_ar_addr;
  assign ar_len_o     = r_ar_len;
  assign ar_size_o    = r_ar_size;
  assign ar_burst_o   = r_ar_burst;
  assign ar_id_o      = r_ar_id;
  assign rtrn_valid_o = r_rtrn_valid;
  assign rtrn_data_o  = r_rtrn_data;
  assign rtrn_tid_o   = r_rtrn_tid;

endmodule

// File: tb/tb_axi_line_refill.sv
// Directed scoreboard bench for axi_line_refill (default parameters).
module tb_axi_line_refill;

`ifdef AXI_LINE_REFILL_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [55:0]  req_paddr_i = '0;
  logic         req_nc_i = 1'b0;
  logic [1:0]   req_tid_i = '0;
  logic         ar_valid_o;
  logic         ar_ready_i = 1'b1;
  logic [63:0]  ar_addr_o;
  logic [7:0]   ar_len_o;
  logic [2:0]   ar_size_o;
  logic [1:0]   ar_burst_o;
  logic [3:0]   ar_id_o;
  logic         r_valid_i = 1'b0;
  logic         r_ready_o;
  logic [63:0]  r_data_i = '0;
  logic [3:0]   r_id_i = '0;
  logic [1:0]   r_resp_i = '0;
  logic         r_last_i = 1'b0;
  logic         rtrn_valid_o;
  logic [127:0] rtrn_data_o;
  logic [1:0]   rtrn_tid_o;
  logic         rtrn_err_o;
  logic         busy_o;

  axi_line_refill u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_paddr_i  (req_paddr_i),
    .req_nc_i     (req_nc_i),
    .req_tid_i    (req_tid_i),
    .ar_valid_o   (ar_valid_o),
    .ar_ready_i   (ar_ready_i),
    .ar_addr_o    (ar_addr_o),
    .ar_len_o     (ar_len_o),
    .ar_size_o    (ar_size_o),
    .ar_burst_o   (ar_burst_o),
    .ar_id_o      (ar_id_o),
    .r_valid_i    (r_valid_i),
    .r_ready_o    (r_ready_o),
    .r_data_i     (r_data_i),
    .r_id_i       (r_id_i),
    .r_resp_i     (r_resp_i),
    .r_last_i     (r_last_i),
    .rtrn_valid_o (rtrn_valid_o),
    .rtrn_data_o  (rtrn_data_o),
    .rtrn_tid_o   (rtrn_tid_o),
    .rtrn_err_o   (rtrn_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } ar_exp_t;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   tid;
    logic         err;
  } rt_exp_t;

  ar_exp_t ar_q[$];
  rt_exp_t rt_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_ar_hs  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_ar(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
    ar_exp_t e;
    e.addr = addr; e.len = len; e.id = id;
    ar_q.push_back(e);
  endtask

  task automatic exp_rt(input logic [63:0] w1, input logic [63:0] w0, input logic [1:0] tid, input logic err);
    rt_exp_t e;
    e.data = {w1, w0}; e.tid = tid; e.err = err;
    rt_q.push_back(e);
  endtask

  task automatic do_req(input logic [55:0] paddr, input logic nc, input logic [1:0] tid);
    bit done = 0;
    req_valid_i = 1'b1; req_paddr_i = paddr; req_nc_i = nc; req_tid_i = tid;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        step();
        done = 1;
      end
    end
    req_valid_i = 1'b0;
    if (!done) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_ar();
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk_i);
      if (ar_valid_o && ar_ready_i) done = 1;
    end
    if (!done) chk("ar_handshake_timeout", 0, 1);
    step();
  endtask

  task automatic beat(input logic [3:0] id, input logic [63:0] data, input logic last, input logic [1:0] resp);
    r_valid_i = 1'b1; r_id_i = id; r_data_i = data; r_last_i = last; r_resp_i = resp;
    step();
    r_valid_i = 1'b0; r_last_i = 1'b0; r_resp_i = '0;
  endtask

  // Scoreboard monitor: compares every AR handshake and every return against the queues
  always @(negedge clk_i) begin
    ar_exp_t ea;
    rt_exp_t er;
    if (rst_ni && ar_valid_o && ar_ready_i) begin
      n_ar_hs++;
      if (ar_q.size() == 0) begin
        chk("ar_unexpected", {64'h0, ar_addr_o}, 128'h0);
        if (ar_addr_o == 64'h0) chk("ar_unexpected_zero", 1, 0);
      end else begin
        ea = ar_q.pop_front();
        chk("ar_addr", ar_addr_o, ea.addr);
        chk("ar_len", ar_len_o, ea.len);
        chk("ar_id", ar_id_o, ea.id);
        chk("ar_size", ar_size_o, 3);
        chk("ar_burst", ar_burst_o, 1);
      end
    end
    if (rtrn_valid_o) begin
      if (rt_q.size() == 0) begin
        chk("rtrn_unexpected", 1, 0);
      end else begin
        er = rt_q.pop_front();
        chk("rtrn_data", rtrn_data_o, er.data);
        chk("rtrn_tid", rtrn_tid_o, er.tid);
        chk("rtrn_err", rtrn_err_o, er.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    // Reset values
    repeat (3) step();
    chk("rst_ar_valid", ar_valid_o, 0);
    chk("rst_rtrn_valid", rtrn_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_r_ready", r_ready_o, 1);
    chk("rst_ar_addr", ar_addr_o, 0);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_req_ready", req_ready_o, 1);
    step();

    // Cacheable line fill, two beats
    exp_ar(64'h8000_1230, 8'd1, 4'd0);
    exp_rt(64'hB, 64'hA, 2'd1, 1'b0);
    do_req(56'h8000_1234, 1'b0, 2'd1);
    wait_ar();
    chk("t1_busy", busy_o, 1);
    beat(4'd0, 64'hA, 1'b0, 2'b00);
    beat(4'd0, 64'hB, 1'b1, 2'b00);
    step(); step();
    chk("t1_idle_busy", busy_o, 0);

    // Non-cacheable single word
    exp_ar(64'h1000, 8'd0, 4'd0);
    exp_rt(64'h0, 64'hC, 2'd2, 1'b0);
    do_req(56'h1004, 1'b1, 2'd2);
    wait_ar();
    beat(4'd0, 64'hC, 1'b1, 2'b00);
    step(); step();

    // Two slots, completion in reverse order
    exp_ar(64'h2000, 8'd1, 4'd0);
    exp_ar(64'h3040, 8'd1, 4'd1);
    exp_rt(64'h32, 64'h31, 2'd3, 1'b0);
    exp_rt(64'h02, 64'h01, 2'd0, 1'b0);
    do_req(56'h2008, 1'b0, 2'd0);
    do_req(56'h3044, 1'b0, 2'd3);
    wait_ar();
    chk("t3_ready_full", req_ready_o, 0);
    beat(4'd1, 64'h31, 1'b0, 2'b00);
    beat(4'd1, 64'h32, 1'b1, 2'b00);
    chk("t3_ready_rtrn_slot", req_ready_o, 0);
    step();
    chk("t3_ready_freed", req_ready_o, 1);
    beat(4'd0, 64'h01, 1'b0, 2'b00);
    beat(4'd0, 64'h02, 1'b1, 2'b00);
    step(); step();
    // Beats to free or nonexistent slots are dropped
    beat(4'd1, 64'h99, 1'b1, 2'b00);
    beat(4'd5, 64'h98, 1'b1, 2'b00);
    step(); step();
    chk("t3_stray_busy", busy_o, 0);

    // AR backpressure, plus a beat arriving before the AR handshake
    ar_ready_i = 1'b0;
    exp_ar(64'h4000, 8'd1, 4'd0);
    exp_rt(64'h42, 64'h41, 2'd2, 1'b0);
    do_req(56'h4008, 1'b0, 2'd2);
    hs0 = n_ar_hs;
    for (int k = 0; k < 5; k++) begin
      chk("t4_ar_valid", ar_valid_o, 1);
      chk("t4_ar_addr", ar_addr_o, 64'h4000);
      chk("t4_ar_len", ar_len_o, 1);
      chk("t4_req_ready", req_ready_o, 0);
      if (k == 2) beat(4'd0, 64'hDEAD, 1'b1, 2'b00);
      else step();
    end
    ar_ready_i = 1'b1;
    wait_ar();
    beat(4'd0, 64'h41, 1'b0, 2'b00);
    beat(4'd0, 64'h42, 1'b1, 2'b00);
    step(); step();
    chk("t4_single_ar_hs", n_ar_hs - hs0, 1);

    // Error response on first beat, then a clean fill
    exp_ar(64'h5000, 8'd1, 4'd0);
    exp_rt(64'h52, 64'h51, 2'd1, ErrEn);
    do_req(56'h5000, 1'b0, 2'd1);
    wait_ar();
    beat(4'd0, 64'h51, 1'b0, 2'b10);
    beat(4'd0, 64'h52, 1'b1, 2'b00);
    step(); step();
    exp_ar(64'h6000, 8'd1, 4'd0);
    exp_rt(64'h62, 64'h61, 2'd2, 1'b0);
    do_req(56'h6000, 1'b0, 2'd2);
    wait_ar();
    beat(4'd0, 64'h61, 1'b0, 2'b00);
    beat(4'd0, 64'h62, 1'b1, 2'b00);
    step(); step();

    // Reset mid-burst abandons the refill
    exp_ar(64'h7000, 8'd1, 4'd0);
    do_req(56'h7000, 1'b0, 2'd3);
    wait_ar();
    beat(4'd0, 64'h71, 1'b0, 2'b00);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_req_ready", req_ready_o, 0);
    chk("mid_rst_rtrn_valid", rtrn_valid_o, 0);
    chk("mid_rst_rtrn_data", rtrn_data_o, 0);
    chk("mid_rst_r_ready", r_ready_o, 1);
    step(); step();
    rst_ni = 1'b1;
    #1;
    chk("post_mid_rst_req_ready", req_ready_o, 1);
    chk("post_mid_rst_busy", busy_o, 0);
    step();
    beat(4'd0, 64'h72, 1'b1, 2'b00);
    step();
    exp_ar(64'h8000, 8'd1, 4'd0);
    exp_rt(64'h82, 64'h81, 2'd0, 1'b0);
    do_req(56'h8000, 1'b0, 2'd0);
    wait_ar();
    beat(4'd0, 64'h81, 1'b0, 2'b00);
    beat(4'd0, 64'h82, 1'b1, 2'b00);
    repeat (5) step();

    chk("ar_queue_drained", ar_q.size(), 0);
    chk("rtrn_queue_drained", rt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_line_refill.md
AXI_LINE_REFILL -- requirements
Module: axi_line_refill

Interface
REQ-001 SHALL have parameter LineWidth, default 128: cache line width in bits; must be a multiple of AxiDataWidth.
REQ-002 SHALL have parameter AxiDataWidth, default 64: R data width; 32, 64, 128 or 256.
REQ-003 SHALL have parameter AxiAddrWidth, default 64: AR address width.
REQ-004 SHALL have parameter PlenWidth, default 56: physical request address width, at most AxiAddrWidth.
REQ-005 SHALL have parameter NumOutstanding, default 2: number of concurrent refills (slots), 1..8.
REQ-006 SHALL have parameter TidWidth, default 2: requester transaction ID width.
REQ-007 SHALL have parameter AxiIdWidth, default 4: AXI ID width, at least clog2(NumOutstanding).
REQ-008 SHALL have ports clk_i in 1 (clock) and rst_ni in 1 (reset, asynchronous, active-low).
REQ-009 SHALL have request ports req_valid_i in 1; req_ready_o out 1; req_paddr_i in PlenWidth; req_nc_i in 1 (non-cacheable, single word); req_tid_i in TidWidth.
REQ-010 SHALL have AR ports ar_valid_o out 1; ar_ready_i in 1; ar_addr_o out AxiAddrWidth; ar_len_o out 8; ar_size_o out 3; ar_burst_o out 2; ar_id_o out AxiIdWidth.
REQ-011 SHALL have R ports r_valid_i in 1; r_ready_o out 1; r_data_i in AxiDataWidth; r_id_i in AxiIdWidth; r_resp_i in 2; r_last_i in 1.
REQ-012 SHALL have return ports rtrn_valid_o out 1; rtrn_data_o out LineWidth; rtrn_tid_o out TidWidth; rtrn_err_o out 1; busy_o out 1 (any slot busy or AR pending).

Function
REQ-013 SHALL set req_ready_o = (some slot is free) AND (no AR pending); a request is accepted on req_valid_i && req_ready_o.
REQ-014 SHALL allocate the lowest-index free slot on acceptance; a slot freed in the same cycle is not reusable until the next cycle.
REQ-015 SHALL register the AR on acceptance and drive ar_valid_o from the next cycle, holding all AR fields stable until ar_ready_i.
REQ-016 SHALL drive ar_id_o = slot index (zero-extended), ar_burst_o = INCR, and ar_size_o = clog2(AxiDataWidth/8).
REQ-017 For cacheable requests, SHALL drive ar_addr_o = paddr aligned down to LineWidth/8 and ar_len_o = LineWidth/AxiDataWidth-1.
REQ-018 For nc requests, SHALL drive ar_addr_o = paddr aligned down to AxiDataWidth/8 and ar_len_o = 0.
REQ-019 SHALL tie r_ready_o to 1; the return path has no backpressure.
REQ-020 SHALL route each R beat to slot r_id_i, writing it at word index = that slot's beat counter; the counter wraps to 0 on r_last_i.
REQ-021 For nc fills, SHALL place the single beat at word 0 and zero the other words.
REQ-022 SHALL drop R beats whose r_id_i addresses a free slot, with no state change.
REQ-023 SHALL assert rtrn_valid_o for exactly one cycle, in the cycle after the r_last_i beat, carrying the slot's assembled line and tid.
REQ-024 SHALL free the slot in that same rtrn cycle.
REQ-025 SHALL support out-of-order completion across slots; returns follow r_last_i order.
REQ-026 A slot SHALL follow the FSM IDLE -> AR_WAIT (ar_valid_o pending) -> DATA (awaiting beats) -> RTRN (one cycle) -> IDLE.
REQ-027 A beat arriving while the slot is still in AR_WAIT SHALL be treated as a protocol error: the beat is dropped and the slot state is unchanged.

Reset
REQ-028 On rst_ni low, SHALL clear all slots to IDLE, beat counters to 0 and data to 0.
REQ-029 During reset, SHALL hold ar_valid_o, rtrn_valid_o, rtrn_err_o, busy_o and req_ready_o at 0; all AR/rtrn data outputs at 0; r_ready_o at 1.
REQ-030 Reset mid-burst SHALL abandon all refills with no rtrn issued; req_ready_o SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-031 With AXI_LINE_REFILL_ERR_EN defined, SHALL keep a per-slot sticky error = OR of r_resp_i[1] over the burst, output on rtrn_err_o with the return and cleared on slot free.
REQ-032 Without AXI_LINE_REFILL_ERR_EN, SHALL tie rtrn_err_o to 0, ignore r_resp_i and keep no error storage.

Structure
REQ-033 SHALL place the slot-state enum (IDLE, AR_WAIT, DATA, RTRN), the per-slot struct (paddr, nc, tid, beat count, err) and the AR burst constants in package axi_line_refill_pkg.
REQ-034 SHALL implement per-slot line assembly (beat counter, data buffer, error flag) as sub-module axi_line_refill_slot, instantiated NumOutstanding times.

Verification
REQ-035 Defaults; request paddr=0x8000_1234, nc=0, tid=1; ar_ready at once; 2 beats 0xA, 0xB with last -> ar_addr=0x8000_1230, ar_len=1, ar_id=0; rtrn_data={0xB,0xA}, tid=1 one cycle after last.
REQ-036 nc request paddr=0x1004 -> ar_addr=0x1000, ar_len=0; beat 0xC -> rtrn_data word0=0xC, word1=0.
REQ-037 Two requests, tid=0 then tid=3; R returns ID1 burst first -> tid=3 returned first, then tid=0; req_ready_o=0 while both slots busy.
REQ-038 ar_ready_i held 0 for 5 cycles -> AR fields stable and req_ready_o=0 throughout; single ar handshake.
REQ-039 With AXI_LINE_REFILL_ERR_EN, r_resp=SLVERR on beat 0 -> rtrn_err_o=1; following fill -> rtrn_err_o=0; without the macro -> rtrn_err_o=0.
REQ-040 rst_ni pulsed after the first beat -> no rtrn_valid_o; busy_o=0; next request completes normally with ar_id=0.
